fixed_to_float_arbiter: RTL and testbench
=========================================

// Module: fixed_to_float_arbiter
// PURPOSE
//  Shares one fixed_to_float converter (AXI-stream, in-order, 7-cycle pipeline, backpressure)
//  between NUM_REQ requesters. Grants issue slots round-robin and records each issued beat's
//  requester index in a tag FIFO. Routes each converter result back to its originating requester.
//  Sits between the per-lane fixed-point producers and the shared conversion datapath.
// PARAMETERS
//  SIZE      32  data width of operands and results
//  NUM_REQ   4   number of requesters (>=2)
//  MAX_INFL  8   tag FIFO depth = max beats in flight inside the converter (power of 2, >= 8)
// PORTS
//  aclk            in   1             clock
//  aresetn         in   1             asynchronous active-low reset
//  req_tdata       in   NUM_REQ*SIZE  requester operands, lane i at [i*SIZE +: SIZE]
//  req_tvalid      in   NUM_REQ       per-requester valid
//  req_tready      out  NUM_REQ       per-requester ready (one-hot or zero)
//  rsp_tdata       out  SIZE          result data, broadcast to all requesters
//  rsp_tvalid      out  NUM_REQ       per-requester result valid (one-hot or zero)
//  rsp_tready      in   NUM_REQ       per-requester result ready
//  cvt_a_tdata     out  SIZE          operand to converter s_axis_a_tdata
//  cvt_a_tvalid    out  1             to converter s_axis_a_tvalid
//  cvt_a_tready    in   1             from converter s_axis_a_tready
//  cvt_r_tdata     in   SIZE          from converter m_axis_result_tdata
//  cvt_r_tvalid    in   1             from converter m_axis_result_tvalid
//  cvt_r_tready    out  1             to converter m_axis_result_tready
//  inflight        out  $clog2(MAX_INFL)+1  tag FIFO occupancy
//  err_orphan      out  1             sticky: result arrived with tag FIFO empty
// BEHAVIOUR
//  - Reset (aresetn=0, async): tag FIFO empty, rr_ptr=0, lock=0, err_orphan=0, inflight=0.
//    While reset is low, cvt_a_tvalid=0, cvt_r_tready=0, all req_tready/rsp_tvalid=0.
//  - Issue: grant = first i with req_tvalid[i], searching from rr_ptr upward mod NUM_REQ.
//    cvt_a_tvalid = |req_tvalid && !fifo_full. cvt_a_tdata = lane[grant].
//    req_tready[grant] = cvt_a_tready && !fifo_full; all others 0.
//  - Lock: if cvt_a_tvalid && !cvt_a_tready, register lock=1, lock_idx=grant. While locked,
//    grant=lock_idx regardless of other valids, so AXI data stays stable. Lock clears on handshake.
//  - Handshake (cvt_a_tvalid && cvt_a_tready): push grant index into tag FIFO; rr_ptr <= grant+1 mod NUM_REQ.
//    rr_ptr does not move without a handshake.
//  - Full: fifo_full blocks issue even if a pop occurs in the same cycle. There is no bypass.
//  - Return: head = FIFO front index. rsp_tvalid[head] = cvt_r_tvalid && !fifo_empty.
//    cvt_r_tready = !fifo_empty && rsp_tready[head]. On cvt_r_tvalid && cvt_r_tready, pop.
//    rsp_tdata = cvt_r_tdata combinationally. Results are strictly in issue order.
//    A stalled head requester blocks all returns (head-of-line). This is intended.
//  - Simultaneous push+pop: occupancy unchanged, both pointers advance. Pointers wrap mod MAX_INFL.
//  - Orphan: cvt_r_tvalid && fifo_empty sets err_orphan (sticky until reset). cvt_r_tready stays 0.
//  - Latency: arbiter adds 0 cycles each way. Request-to-result = converter latency (7) when unstalled.
//  - Reset mid-operation: FIFO and tags discarded. The converter shares aresetn, so its
//    in-flight beats are flushed too. No result is delivered after reset release
//    without a new request.
// STRUCTURE
//  - fp_arb_pkg: localparam-style functions idx_w(NUM_REQ), and typedef req_idx_t for tags.
//  - Sub-module tag_fifo: sync FIFO, width idx_w, depth MAX_INFL, with count/full/empty,
//    async active-low reset.
//  - Top-level holds the rr arbiter, lock register and routing muxes.
// TESTING
//  1. Single requester: lane1 sends 5 beats (1,2,3,4,5), rsp_tready=all 1
//     -> lane1 gets bits of 1.0..5.0, 7 cycles after each issue. Other rsp_tvalid stay 0.
//  2. All 4 lanes valid continuously -> issue order 0,1,2,3,0,1,...
//     Each lane receives exactly its own values, in order.
//  3. cvt_a_tready=0 for 3 cycles while lane2 is locked, and lane0 raises valid
//     -> cvt_a_tdata stays lane2's value. Lane2 is issued first, then lane3/lane0 per rr.
//  4. rsp_tready[head]=0 for 20 cycles -> inflight saturates at 8.
//     cvt_a_tvalid=0 while full. No beats are lost after release.
//  5. Force cvt_r_tvalid=1 with FIFO empty -> err_orphan=1, held until reset, cvt_r_tready=0.
//  6. Assert aresetn=0 with 4 beats in flight -> inflight=0 immediately.
//     No rsp_tvalid after release until new requests are issued.

Source files
------------

// File: rtl/fixed_to_float_arbiter_pkg.sv
// Shared types and helpers for the fixed_to_float converter arbiter.
// Requester tags are idx_w(NUM_REQ) bits wide; the lock state is a two-state enum.
package fp_arb_pkg;

  localparam int SIZE_DEF     = 32;
  localparam int NUM_REQ_DEF  = 4;
  localparam int MAX_INFL_DEF = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_REQ_DEF);

  typedef logic [IDX_W_DEF-1:0] req_idx_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/fixed_to_float_arbiter_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each beat inside the converter.
// Pointers wrap naturally because DEPTH is a power of two.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             front,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fixed_to_float_arbiter.sv
// Round-robin arbiter sharing one in-order fixed_to_float converter among NUM_REQ lanes.
// Issued beats are tagged in a FIFO so each result is routed back to its requester.
module fixed_to_float_arbiter
  import fp_arb_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int MAX_INFL = MAX_INFL_DEF
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ*SIZE-1:0]     req_tdata,
  input  logic [NUM_REQ-1:0]          req_tvalid,
  output logic [NUM_REQ-1:0]          req_tready,
  output logic [SIZE-1:0]             rsp_tdata,
  output logic [NUM_REQ-1:0]          rsp_tvalid,
  input  logic [NUM_REQ-1:0]          rsp_tready,
  output logic [SIZE-1:0]             cvt_a_tdata,
  output logic                        cvt_a_tvalid,
  input  logic                        cvt_a_tready,
  input  logic [SIZE-1:0]             cvt_r_tdata,
  input  logic                        cvt_r_tvalid,
  output logic                        cvt_r_tready,
  output logic [$clog2(MAX_INFL):0]   inflight,
  output logic                        err_orphan
);

  localparam int IW = idx_w(NUM_REQ);

  // Handshakes: a beat moves on any interface when valid and ready are both high at
  // the rising clock edge; once valid is raised toward the converter the offered
  // data is held (via the lock) until that handshake happens.

  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] search_grant;
  logic [IW-1:0] cand;
  logic [IW-1:0] grant;
  logic [IW-1:0] head;
  logic          found;
  logic          locked;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issue_hs;
  logic          issue_stall;
  logic          ret_hs;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    search_grant = rr_ptr;
    cand         = rr_ptr;
    found        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_tvalid[cand]) begin
        search_grant = cand;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ARB_OPEN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_OPEN:   if (issue_stall) state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (issue_hs)    state_nxt = ARB_OPEN;
      default:    state_nxt = ARB_OPEN;
    endcase
  end

  always_comb begin
    locked = (state == ARB_LOCKED);
    grant  = locked ? lock_idx : search_grant;
  end

  assign cvt_a_tvalid = aresetn && (|req_tvalid) && !fifo_full;
  assign cvt_a_tdata  = req_tdata[int'(grant)*SIZE +: SIZE];
  assign issue_hs     = cvt_a_tvalid && cvt_a_tready;
  assign issue_stall  = cvt_a_tvalid && !cvt_a_tready;

  always_comb begin
    req_tready = '0;
    if (aresetn && cvt_a_tready && !fifo_full) req_tready[grant] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      if (issue_hs)    rr_ptr   <= IW'(rr_next(int'(grant), NUM_REQ));
      if (issue_stall) lock_idx <= grant;
    end
  end

  tag_fifo #(
    .W     (IW),
    .DEPTH (MAX_INFL)
  ) u_tag_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (issue_hs),
    .push_data (grant),
    .pop       (ret_hs),
    .front     (head),
    .count     (inflight),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Results come back in issue order, so the FIFO head names the destination.
  assign cvt_r_tready = aresetn && !fifo_empty && rsp_tready[head];
  assign ret_hs       = cvt_r_tvalid && cvt_r_tready;
  assign rsp_tdata    = cvt_r_tdata;

  always_comb begin
    rsp_tvalid = '0;
    if (aresetn && cvt_r_tvalid && !fifo_empty) rsp_tvalid[head] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                        err_orphan <= 1'b0;
    else if (cvt_r_tvalid && fifo_empty) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_fixed_to_float_arbiter.sv
// Bench for fixed_to_float_arbiter: a 7-cycle in-order converter model on the shared side,
// per-lane expected queues filled at stimulus time and drained as results return.
module tb_fixed_to_float_arbiter;

  localparam int SIZE     = 32;
  localparam int NUM_REQ  = 4;
  localparam int MAX_INFL = 8;
  localparam int LAT      = 7;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [NUM_REQ*SIZE-1:0] req_tdata = '0;
  logic [NUM_REQ-1:0]      req_tvalid = '0;
  logic [NUM_REQ-1:0]      req_tready;
  logic [SIZE-1:0]         rsp_tdata;
  logic [NUM_REQ-1:0]      rsp_tvalid;
  logic [NUM_REQ-1:0]      rsp_tready = '0;
  logic [SIZE-1:0]         cvt_a_tdata;
  logic                    cvt_a_tvalid;
  logic                    cvt_a_tready = 1'b0;
  logic [SIZE-1:0]         cvt_r_tdata = '0;
  logic                    cvt_r_tvalid = 1'b0;
  logic                    cvt_r_tready;
  logic [3:0]              inflight;
  logic                    err_orphan;

  fixed_to_float_arbiter #(
    .SIZE     (SIZE),
    .NUM_REQ  (NUM_REQ),
    .MAX_INFL (MAX_INFL)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .req_tdata    (req_tdata),
    .req_tvalid   (req_tvalid),
    .req_tready   (req_tready),
    .rsp_tdata    (rsp_tdata),
    .rsp_tvalid   (rsp_tvalid),
    .rsp_tready   (rsp_tready),
    .cvt_a_tdata  (cvt_a_tdata),
    .cvt_a_tvalid (cvt_a_tvalid),
    .cvt_a_tready (cvt_a_tready),
    .cvt_r_tdata  (cvt_r_tdata),
    .cvt_r_tvalid (cvt_r_tvalid),
    .cvt_r_tready (cvt_r_tready),
    .inflight     (inflight),
    .err_orphan   (err_orphan)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- bench state ----------------
  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lane;
  } conv_t;

  conv_t       conv_q[$];
  logic [31:0] lane_pend [NUM_REQ][$];
  logic [31:0] exp_q     [NUM_REQ][$];
  int          issue_log[$];
  int          cyc = 0;
  int          tb_infl = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        cvt_rdy_en = 1'b1;
  logic        force_orphan = 1'b0;
  logic        lat_chk = 1'b0;
  logic [NUM_REQ-1:0] rsp_rdy = '1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Nonnegative integer below 2^24 to IEEE-754 single (exact).
  function automatic logic [31:0] cvt_fn(input logic [31:0] v);
    int          msb;
    logic [31:0] m;
    if (v == 32'd0) return 32'd0;
    msb = 0;
    for (int b = 0; b < 24; b++) if (v[b]) msb = b;
    m = v << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic bit busy();
    bit b;
    b = (conv_q.size() != 0);
    for (int i = 0; i < NUM_REQ; i++)
      if (lane_pend[i].size() != 0 || exp_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int lane, input logic [31:0] v, input logic [31:0] expf);
    lane_pend[lane].push_back(v);
    exp_q[lane].push_back(expf);
  endtask

  // One cycle: drive at negedge, sample 1 time unit later, account for the coming edge.
  task automatic step();
    int            acc_lane;
    conv_t         e;
    logic [NUM_REQ-1:0] oh;
    @(negedge aclk);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tvalid[i] = (lane_pend[i].size() != 0);
      req_tdata[i*SIZE +: SIZE] = (lane_pend[i].size() != 0) ? lane_pend[i][0] : 32'd0;
    end
    cvt_a_tready = cvt_rdy_en;
    rsp_tready   = rsp_rdy;
    if (force_orphan) begin
      cvt_r_tvalid = 1'b1;
      cvt_r_tdata  = 32'hDEAD_BEEF;
    end else if (conv_q.size() != 0 && cyc >= conv_q[0].issue + LAT) begin
      cvt_r_tvalid = 1'b1;
      cvt_r_tdata  = conv_q[0].data;
    end else begin
      cvt_r_tvalid = 1'b0;
      cvt_r_tdata  = 32'd0;
    end
    #1;
    chk("req_ready_onehot0", 64'($onehot0(req_tready)), 1);
    chk("rsp_valid_onehot0", 64'($onehot0(rsp_tvalid)), 1);
    chk("inflight_track", inflight, 64'(tb_infl));
    if (tb_infl == MAX_INFL) chk("full_blocks_issue", cvt_a_tvalid, 0);
    if (lat_chk) chk("t1_other_rsp", rsp_tvalid & 4'b1101, 0);

    acc_lane = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_tvalid[i] && req_tready[i]) acc_lane = i;
    if (cvt_a_tvalid && cvt_a_tready) begin
      if (acc_lane < 0) chk("issue_lane_hs", |(req_tvalid & req_tready), 1);
      else begin
        chk("issue_data", cvt_a_tdata, lane_pend[acc_lane][0]);
        e.data  = cvt_fn(cvt_a_tdata);
        e.issue = cyc;
        e.lane  = acc_lane;
        conv_q.push_back(e);
        void'(lane_pend[acc_lane].pop_front());
        issue_log.push_back(acc_lane);
        tb_infl++;
      end
    end else if (acc_lane >= 0) begin
      chk("lane_hs_without_issue", {cvt_a_tvalid, cvt_a_tready}, 2'b11);
    end

    if (cvt_r_tvalid && cvt_r_tready) begin
      if (conv_q.size() == 0) chk("ret_without_beat", cvt_r_tready, 0);
      else begin
        e = conv_q.pop_front();
        tb_infl--;
        oh = '0;
        oh[e.lane] = 1'b1;
        chk("rsp_route", rsp_tvalid, oh);
        chk("rsp_data_bus", rsp_tdata, e.data);
        if (exp_q[e.lane].size() == 0) chk("rsp_unexpected", rsp_tvalid, 0);
        else chk($sformatf("rsp_lane%0d", e.lane), rsp_tdata, exp_q[e.lane].pop_front());
        if (lat_chk) chk("latency", 64'(cyc - e.issue), LAT);
      end
    end else if (|(rsp_tvalid & rsp_tready)) begin
      chk("rsp_hs_without_ret", cvt_r_tready, 1);
    end
    cyc++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(busy()), 0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_cvt_a_tvalid", cvt_a_tvalid, 0);
    chk("rst_cvt_r_tready", cvt_r_tready, 0);
    chk("rst_req_tready", req_tready, 0);
    chk("rst_rsp_tvalid", rsp_tvalid, 0);
    conv_q.delete();
    issue_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_pend[i].delete();
      exp_q[i].delete();
    end
    tb_infl = 0;
    force_orphan = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    do_reset();

    // 1: single requester, exact float constants and latency
    lat_chk = 1'b1;
    send(1, 32'd1, 32'h3F80_0000);
    send(1, 32'd2, 32'h4000_0000);
    send(1, 32'd3, 32'h4040_0000);
    send(1, 32'd4, 32'h4080_0000);
    send(1, 32'd5, 32'h40A0_0000);
    wait_idle(100);
    lat_chk = 1'b0;

    // 2: all lanes busy -> strict rotation from lane 0
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < NUM_REQ; l++)
        send(l, 32'(1000 * (l + 1) + b + $urandom_range(0, 9) * 10), 32'd0);
    for (int l = 0; l < NUM_REQ; l++)
      for (int b = 0; b < exp_q[l].size(); b++) exp_q[l][b] = cvt_fn(lane_pend[l][b]);
    wait_idle(200);
    chk("t2_count", 64'(issue_log.size()), 16);
    foreach (issue_log[k]) chk("t2_order", 64'(issue_log[k]), 64'(k % NUM_REQ));

    // 3: lock holds lane 2 while the converter stalls (rr_ptr is back at 0 here)
    issue_log.delete();
    cvt_rdy_en = 1'b0;
    send(2, 32'd777, cvt_fn(32'd777));
    step();
    send(0, 32'd10, cvt_fn(32'd10));
    send(3, 32'd30, cvt_fn(32'd30));
    repeat (3) begin
      step();
      chk("t3_lock_data", cvt_a_tdata, 777);
      chk("t3_no_ready", req_tready, 0);
    end
    cvt_rdy_en = 1'b1;
    wait_idle(100);
    chk("t3_count", 64'(issue_log.size()), 3);
    if (issue_log.size() == 3) begin
      chk("t3_first", 64'(issue_log[0]), 2);
      chk("t3_second", 64'(issue_log[1]), 3);
      chk("t3_third", 64'(issue_log[2]), 0);
    end

    // 4: stalled head saturates the tag FIFO
    rsp_rdy = '0;
    for (int b = 0; b < 12; b++) send(0, 32'(200 + b), cvt_fn(32'(200 + b)));
    repeat (20) step();
    chk("t4_inflight_sat", inflight, 8);
    chk("t4_issue_blocked", cvt_a_tvalid, 0);
    chk("t4_pending", 64'(lane_pend[0].size()), 4);
    rsp_rdy = '1;
    wait_idle(200);

    // 5: orphan result
    do_reset();
    force_orphan = 1'b1;
    step();
    chk("t5_orphan_ready", cvt_r_tready, 0);
    chk("t5_orphan_rsp", rsp_tvalid, 0);
    force_orphan = 1'b0;
    step();
    chk("t5_err_set", err_orphan, 1);
    repeat (5) step();
    chk("t5_err_sticky", err_orphan, 1);

    // 6: reset with beats in flight
    do_reset();
    for (int l = 0; l < NUM_REQ; l++) send(l, 32'(50 + l), cvt_fn(32'(50 + l)));
    n = 0;
    while (tb_infl < 4 && n < 20) begin
      step();
      n++;
    end
    step();
    chk("t6_inflight4", inflight, 4);
    do_reset();
    repeat (15) begin
      step();
      chk("t6_no_rsp", rsp_tvalid, 0);
      chk("t6_no_issue", cvt_a_tvalid, 0);
    end
    send(2, 32'd42, cvt_fn(32'd42));
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
